// File: rtl/bch_enc_pkg.sv
// -----------------------------------------------------------------------------
// bch_enc_pkg
// Shared BCH code parameters (as produced by bch_parameters) and the encoder
// state type. Encoder and decoder blocks import this package so every block
// agrees on the field size, code geometry and generator polynomial.
//
// Contents:
//   BCH_M, BCH_N, BCH_K, BCH_T : GF(2^m) size, code length, data length,
//                                correctable errors
//   BCH_GEN_POLY               : generator polynomial, n-k+1 bits,
//                                MSB = x^(n-k)
//   bch_enc_state_e            : encoder FSM states
// -----------------------------------------------------------------------------
package bch_enc_pkg;

  localparam int BCH_M = 4;
  localparam int BCH_N = 15;
  localparam int BCH_K = 7;
  localparam int BCH_T = 2;

  // g(x) = x^8 + x^7 + x^6 + x^4 + 1
  localparam logic [BCH_N-BCH_K:0] BCH_GEN_POLY = 9'h1D1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } bch_enc_state_e;

endpackage

// File: rtl/bch_enc_lfsr.sv
// -----------------------------------------------------------------------------
// bch_enc_lfsr
// Parity register of the systematic BCH encoder: a P-bit division LFSR that
// accumulates the remainder of m(x)*x^P mod g(x) while data streams in, and
// then shifts that remainder out MSB first.
//
// Parameters:
//   P    : number of parity bits (n-k)
//   POLY : generator polynomial without its x^P term
// Ports:
//   i_clk    input  clock
//   i_rst_n  input  synchronous active-low reset (register cleared)
//   i_clr    input  start of frame: divide starting from an all-zero register
//   i_fb_en  input  absorb one data bit (i_dat) through the feedback path
//   i_shift  input  shift the register left by one (parity readout)
//   i_dat    input  data bit, highest-degree coefficient first
//   o_msb    output current register MSB (next parity bit)
// -----------------------------------------------------------------------------
module bch_enc_lfsr
  import bch_enc_pkg::*;
#(
  parameter int             P    = BCH_N - BCH_K,
  parameter logic [P-1:0]   POLY = P'(BCH_GEN_POLY)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_fb_en,
  input  logic i_shift,
  input  logic i_dat,
  output logic o_msb
);

  logic [P-1:0] r_par;
  logic [P-1:0] w_base;

  // One division step: feedback is the incoming bit xored with the bit
  // falling out of the top of the register.
  function automatic logic [P-1:0] lfsr_step(input logic [P-1:0] state,
                                             input logic         din);
    logic         fb;
    logic [P-1:0] shifted;
    fb      = din ^ state[P-1];
    shifted = state << 1;
    if (fb) begin
      lfsr_step = shifted ^ POLY;
    end else begin
      lfsr_step = shifted;
    end
  endfunction

  // A new frame divides from zero, so the first bit sees a cleared register
  // without needing a separate clear cycle.
  assign w_base = i_clr ? '0 : r_par;
  assign o_msb  = r_par[P-1];

  // Remainder register: data absorb has priority over parity readout.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_par <= '0;
    end else if (i_fb_en) begin
      r_par <= lfsr_step(w_base, i_dat);
    end else if (i_shift) begin
      r_par <= r_par << 1;
    end else begin
      r_par <= r_par;
    end
  end

endmodule

// File: rtl/bch_enc.sv
// -----------------------------------------------------------------------------
// bch_enc
// Bit-serial systematic BCH encoder. Each frame is k data bits (highest-degree
// coefficient first) echoed to the output with one cycle of latency, followed
// by n-k parity bits MSB first. Output is contiguous from the last data bit
// through the last parity bit, and a new frame may start in the cycle after
// the last parity cycle.
//
// Optional feature macro: BCH_ENC_SHORTEN_EN
//   When defined, an accepted bit with ieop=1 ends the data phase early,
//   producing a shortened codeword of (bits accepted)+(n-k) bits. When not
//   defined, ieop is ignored and no shortening logic is built.
//
// Parameters: m, n, k, GEN_POLY (defaults from bch_enc_pkg)
// Ports:
//   iclk    input  clock
//   ireset  input  synchronous active-low reset
//   ival    input  input bit valid
//   isop    input  first data bit of frame
//   ieop    input  last data bit of a shortened frame
//   idat    input  data bit
//   ordy    output encoder accepts a bit this cycle (combinational)
//   oval    output codeword bit valid
//   osop    output first codeword bit
//   oeop    output last codeword bit
//   odat    output codeword bit
// -----------------------------------------------------------------------------
module bch_enc
  import bch_enc_pkg::*;
#(
  parameter int           m        = BCH_M,
  parameter int           n        = BCH_N,
  parameter int           k        = BCH_K,
  parameter logic [n-k:0] GEN_POLY = BCH_GEN_POLY
) (
  input  logic iclk,
  input  logic ireset,
  input  logic ival,
  input  logic isop,
  input  logic ieop,
  input  logic idat,
  output logic ordy,
  output logic oval,
  output logic osop,
  output logic oeop,
  output logic odat
);

  localparam int P  = n - k;
  localparam int CW = $clog2(k + 1);
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(k - 1);
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);

  // A code longer than the field allows is a configuration error.
  if (n > (1 << m) - 1) begin : g_bad_cfg
    $error("bch_enc: n exceeds 2^m-1");
  end

  bch_enc_state_e r_state;
  bch_enc_state_e w_state_nxt;
  logic [CW-1:0]  r_dcnt;
  logic [PW-1:0]  r_pcnt;
  logic           w_start;
  logic           w_data_step;
  logic           w_par_shift;
  logic           w_par_last;
  logic           w_eop;
  logic           w_par_msb;

`ifdef BCH_ENC_SHORTEN_EN
  assign w_eop = ieop;
`else
  logic w_unused_ieop;
  assign w_eop         = 1'b0;
  assign w_unused_ieop = ieop;
`endif

  // Next-state, ready and datapath controls. ordy is 1 exactly in IDLE/DATA,
  // so ival alone qualifies acceptance in those states.
  always_comb begin
    w_state_nxt = r_state;
    ordy        = 1'b0;
    w_start     = 1'b0;
    w_data_step = 1'b0;
    w_par_shift = 1'b0;
    w_par_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ordy = 1'b1;
        // Bits without isop are dropped while idle.
        if (ival && isop) begin
          w_start     = 1'b1;
          w_data_step = 1'b1;
          if ((k == 1) || w_eop) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        ordy = 1'b1;
        // isop inside a frame is ordinary data.
        if (ival) begin
          w_data_step = 1'b1;
          if ((r_dcnt == K_LAST) || w_eop) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_PARITY: begin
        w_par_shift = 1'b1;
        if (r_pcnt == P_LAST) begin
          w_par_last  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data-bit counter (restarts at 1 on the frame's first bit) and
  // parity-bit counter (modulo n-k, wraps on the last parity bit).
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      r_dcnt <= '0;
      r_pcnt <= '0;
    end else begin
      if (w_start) begin
        r_dcnt <= CW'(1);
      end else if (w_data_step) begin
        r_dcnt <= r_dcnt + CW'(1);
      end else begin
        r_dcnt <= r_dcnt;
      end
      if (w_par_shift) begin
        r_pcnt <= w_par_last ? '0 : (r_pcnt + PW'(1));
      end else begin
        r_pcnt <= r_pcnt;
      end
    end
  end

  // Registered codeword stream: data bits echo one cycle after acceptance,
  // parity bits follow straight from the register MSB.
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      oval <= 1'b0;
      osop <= 1'b0;
      oeop <= 1'b0;
      odat <= 1'b0;
    end else if (w_data_step) begin
      oval <= 1'b1;
      osop <= w_start;
      oeop <= 1'b0;
      odat <= idat;
    end else if (w_par_shift) begin
      oval <= 1'b1;
      osop <= 1'b0;
      oeop <= w_par_last;
      odat <= w_par_msb;
    end else begin
      oval <= 1'b0;
      osop <= 1'b0;
      oeop <= 1'b0;
      odat <= 1'b0;
    end
  end

  bch_enc_lfsr #(
    .P    (P),
    .POLY (GEN_POLY[P-1:0])
  ) u_lfsr (
    .i_clk   (iclk),
    .i_rst_n (ireset),
    .i_clr   (w_start),
    .i_fb_en (w_data_step),
    .i_shift (w_par_shift),
    .i_dat   (idat),
    .o_msb   (w_par_msb)
  );

endmodule

// File: tb/tb_bch_enc.sv
// -----------------------------------------------------------------------------
// tb_bch_enc
// Self-checking bench for bch_enc configured as BCH(15,7), g = 0x1D1.
// Expected codewords come from polynomial long division of m(x)*x^8 by g(x);
// each expected output bit carries the cycle in which it must appear, and a
// monitor compares the DUT stream against that list on every cycle.
// Shortened-frame cases run when BCH_ENC_SHORTEN_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bch_enc;

  localparam int         K = 7;
  localparam int         P = 8;
  localparam logic [8:0] G = 9'h1D1;

  typedef struct {
    logic dat;
    logic sop;
    logic eop;
    int   cyc;
  } exp_t;

  logic iclk   = 1'b0;
  logic ireset = 1'b0;
  logic ival   = 1'b0;
  logic isop   = 1'b0;
  logic ieop   = 1'b0;
  logic idat   = 1'b0;
  logic ordy, oval, osop, oeop, odat;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  logic [63:0] cap      = 64'd0;
  int          cap_n    = 0;
  exp_t        exp_q[$];

  // Clock.
  always #5 iclk = ~iclk;

  // Cycle counter used to timestamp expected outputs.
  always @(posedge iclk) cyc <= cyc + 1;

  bch_enc dut (
    .iclk  (iclk),
    .ireset(ireset),
    .ival  (ival),
    .isop  (isop),
    .ieop  (ieop),
    .idat  (idat),
    .ordy  (ordy),
    .oval  (oval),
    .osop  (osop),
    .oeop  (oeop),
    .odat  (odat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Remainder of msg(x)*x^P divided by g(x), by schoolbook long division.
  function automatic logic [P-1:0] model_parity(input logic [63:0] msg, input int len);
    bit          a[0:127];
    logic [P-1:0] par;
    for (int i = 0; i < 128; i++) a[i] = 1'b0;
    for (int i = 0; i < len; i++) a[i] = msg[len-1-i];
    for (int i = 0; i < len; i++) begin
      if (a[i]) begin
        for (int j = 0; j <= P; j++) a[i+j] = a[i+j] ^ G[P-j];
      end
    end
    for (int j = 0; j < P; j++) par[P-1-j] = a[len+j];
    return par;
  endfunction

  // Monitor: every cycle, either the next expected bit is due or oval must be low.
  initial begin
    exp_t e;
    forever begin
      @(negedge iclk);
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          chk("out_missing_at_cycle", 64'(cyc), 64'(exp_q[0].cyc));
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          chk("out_val_sop_eop_dat", {oval, osop, oeop, odat}, {1'b1, e.sop, e.eop, e.dat});
        end else begin
          chk("out_idle_oval", oval, 1'b0);
        end
        if (oval === 1'b1) begin
          cap = {cap[62:0], odat};
          cap_n++;
        end
      end
    end
  end

  // Send the first nsend bits of a len-bit message (MSB first); a full frame
  // also gets its parity queued and the ordy-low window measured.
  task automatic send_frame(input logic [63:0] msg, input int len, input int nsend,
                            input int gap_pct, input bit use_eop);
    logic [P-1:0] par;
    int           nz;
    for (int i = 0; i < nsend; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 4; g++) begin
          if ($urandom_range(99) < gap_pct) begin
            ival = 1'b0;
            isop = 1'($urandom);
            ieop = 1'($urandom);
            idat = 1'($urandom);
            @(posedge iclk); #1;
          end
        end
      end
      chk("ordy_during_data", ordy, 1'b1);
      ival = 1'b1;
      idat = msg[len-1-i];
      isop = (i == 0) ? 1'b1 : 1'($urandom);
`ifdef BCH_ENC_SHORTEN_EN
      ieop = use_eop && (i == len - 1);
`else
      ieop = 1'($urandom) | (use_eop & 1'b0);
`endif
      exp_q.push_back('{dat: idat, sop: (i == 0), eop: 1'b0, cyc: cyc + 1});
      @(posedge iclk); #1;
    end
    ival = 1'b0;
    isop = 1'b0;
    ieop = 1'b0;
    if (nsend == len) begin
      par = model_parity(msg, len);
      for (int j = 0; j < P; j++)
        exp_q.push_back('{dat: par[P-1-j], sop: 1'b0, eop: (j == P - 1), cyc: cyc + 1 + j});
      nz = 0;
      while (ordy !== 1'b1 && nz < 20) begin
        nz++;
        @(posedge iclk); #1;
      end
      chk("ordy_low_cycles", 64'(nz), 64'(P));
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() > 0 && w < 50) begin
      w++;
      @(posedge iclk); #1;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Reset mid-stream: outputs already registered stay, nothing later appears.
  task automatic do_reset();
    ival   = 1'b0;
    isop   = 1'b0;
    ieop   = 1'b0;
    ireset = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    repeat (2) begin @(posedge iclk); #1; end
    ireset = 1'b1;
  endtask

  task automatic idle(input int ncyc);
    ival = 1'b0;
    repeat (ncyc) begin @(posedge iclk); #1; end
  endtask

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Main stimulus.
  initial begin
    int          s;
    logic [63:0] m1;
    ireset = 1'b0;
    repeat (3) begin @(posedge iclk); #1; end
    mon_en = 1'b1;
    chk("rst_oval", oval, 1'b0);
    chk("rst_osop", osop, 1'b0);
    chk("rst_oeop", oeop, 1'b0);
    chk("rst_odat", odat, 1'b0);
    chk("rst_ordy", ordy, 1'b1);
    ireset = 1'b1;
    idle(2);

    // Pin the reference model to hand-computed remainders.
    chk("model_par_0000001", model_parity(64'd1, 7), 8'hD1);
    chk("model_par_1111111", model_parity(64'h7F, 7), 8'hFF);
    chk("model_par_0000000", model_parity(64'd0, 7), 8'h00);

    // All-zero frame.
    s = cap_n;
    send_frame(64'd0, K, K, 0, 1'b0);
    drain();
    chk("zero_frame_len", 64'(cap_n - s), 64'd15);
    chk("zero_frame_bits", cap[14:0], 15'd0);

    // Single trailing one.
    s = cap_n;
    send_frame(64'd1, K, K, 0, 1'b0);
    drain();
    chk("frame_0000001_len", 64'(cap_n - s), 64'd15);
    chk("frame_0000001_bits", cap[14:0], 15'b0000001_11010001);

    // All ones.
    s = cap_n;
    send_frame(64'h7F, K, K, 0, 1'b0);
    drain();
    chk("frame_1111111_bits", cap[14:0], 15'b1111111_11111111);

    // Bits without isop while idle are dropped.
    repeat (4) begin
      ival = 1'b1; isop = 1'b0; ieop = 1'b0; idat = 1'($urandom);
      @(posedge iclk); #1;
    end
    idle(2);

    // Back-to-back frames with input gaps.
    send_frame(64'($urandom_range(0, 127)), K, K, 40, 1'b0);
    send_frame(64'($urandom_range(0, 127)), K, K, 40, 1'b0);
    drain();

    // Reset after three accepted bits, then a normal frame.
    send_frame(64'h55, K, 3, 0, 1'b0);
    do_reset();
    idle(5);
    chk("post_reset_ordy", ordy, 1'b1);
    s = cap_n;
    send_frame(64'd1, K, K, 0, 1'b0);
    drain();
    chk("post_reset_len", 64'(cap_n - s), 64'd15);
    chk("post_reset_bits", cap[14:0], 15'b0000001_11010001);

    // Random frames, random gaps, mostly back-to-back.
    for (int f = 0; f < 20; f++) begin
      m1 = 64'($urandom_range(0, 127));
      send_frame(m1, K, K, $urandom_range(0, 50), 1'b0);
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
    end
    drain();

`ifdef BCH_ENC_SHORTEN_EN
    // Shortened 3-bit frame.
    s = cap_n;
    send_frame(64'b001, 3, 3, 0, 1'b1);
    drain();
    chk("short_001_len", 64'(cap_n - s), 64'd11);
    chk("short_001_bits", cap[10:0], 11'b001_11010001);
    // One-bit frame: isop and ieop together.
    s = cap_n;
    send_frame(64'd1, 1, 1, 0, 1'b1);
    drain();
    chk("short_1bit_len", 64'(cap_n - s), 64'd9);
    chk("short_1bit_bits", cap[8:0], 9'b1_11010001);
    for (int f = 0; f < 6; f++) begin
      s = $urandom_range(1, K);
      send_frame(64'($urandom), s, s, 20, 1'b1);
    end
    drain();
`endif

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
